// File: rtl/alu_bit_serial_sequencer.sv
// Bit-serial sequencer: walks a 1-bit ALU slice LSB to MSB, one bit per clock,
// and assembles the WIDTH-bit result with carry, zero and overflow flags.
module alu_bit_serial_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [1:0]       ALUOp,
    input  logic             Sub,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceCIN,
    output logic             SliceBInvert,
    output logic [1:0]       SliceOperation,
    input  logic             SliceResult,
    input  logic             SliceCOUT,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Overflow,
    output logic [1:0]       DbgState
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [1:0] OP_ADD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: Start is sampled at a rising edge only in IDLE or DONE; an
    // accepted Start yields Busy for WIDTH cycles, then a one-cycle Done.
    state_t            state_q,    state_d;
    logic [WIDTH-1:0]  op_a_q,     op_a_d;
    logic [WIDTH-1:0]  op_b_q,     op_b_d;
    logic [1:0]        alu_op_q,   alu_op_d;
    logic              sub_q,      sub_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              carry_q,    carry_d;
    logic [WIDTH-1:0]  res_q,      res_d;
    logic              msb_cin_q,  msb_cin_d;
    logic              cout_q,     cout_d;
    logic              is_add_q,   is_add_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        alu_op_d  = alu_op_q;
        sub_d     = sub_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        res_d     = res_q;
        msb_cin_d = msb_cin_q;
        cout_d    = cout_q;
        is_add_d  = is_add_q;

        case (state_q)
            S_RUN: begin
                res_d[idx_q] = SliceResult;
                carry_d      = SliceCOUT;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags are only meaningful for ADD; is_add_q masks them.
                    msb_cin_d = carry_q;
                    cout_d    = SliceCOUT;
                    is_add_d  = (alu_op_q == OP_ADD);
                    idx_d     = '0;
                    state_d   = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                if (Start) begin
                    op_a_d    = OpA;
                    op_b_d    = OpB;
                    alu_op_d  = ALUOp;
                    sub_d     = Sub;
                    idx_d     = '0;
                    carry_d   = Sub;
                    res_d     = '0;
                    msb_cin_d = 1'b0;
                    cout_d    = 1'b0;
                    is_add_d  = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            alu_op_q  <= '0;
            sub_q     <= 1'b0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            res_q     <= '0;
            msb_cin_q <= 1'b0;
            cout_q    <= 1'b0;
            is_add_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            alu_op_q  <= alu_op_d;
            sub_q     <= sub_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            res_q     <= res_d;
            msb_cin_q <= msb_cin_d;
            cout_q    <= cout_d;
            is_add_q  <= is_add_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The slice sees the registered carry only; its COUT never loops back combinationally.
    always_comb begin
        SliceA         = 1'b0;
        SliceB         = 1'b0;
        SliceCIN       = 1'b0;
        SliceBInvert   = 1'b0;
        SliceOperation = 2'b00;
        if (state_q == S_RUN) begin
            SliceA         = op_a_q[idx_q];
            SliceB         = op_b_q[idx_q];
            SliceCIN       = carry_q;
            SliceBInvert   = sub_q;
            SliceOperation = alu_op_q;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = res_q;
    assign Zero     = ~|res_q;
    assign CarryOut = is_add_q & cout_q;
    assign Overflow = is_add_q & (msb_cin_q ^ cout_q);
    assign DbgState = state_q;

endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// Bench for alu_bit_serial_sequencer: a behavioural 1-bit ALU slice feeds the
// sequencer, and whole-word results are compared with arithmetic reference values.
module tb_alu_bit_serial_sequencer;
  localparam int W = 16;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] op_a, op_b;
  logic [1:0] alu_op;
  logic sub;
  logic s_a, s_b, s_cin, s_binv;
  logic [1:0] s_oper;
  logic s_res, s_cout;
  logic busy, done, carry_out, zero, overflow;
  logic [W-1:0] result;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         s;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } vec_t;

  always #5 clk = ~clk;

  alu_bit_serial_sequencer #(.WIDTH(W)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start),
    .OpA(op_a), .OpB(op_b), .ALUOp(alu_op), .Sub(sub),
    .SliceA(s_a), .SliceB(s_b), .SliceCIN(s_cin), .SliceBInvert(s_binv),
    .SliceOperation(s_oper), .SliceResult(s_res), .SliceCOUT(s_cout),
    .Busy(busy), .Done(done), .Result(result), .CarryOut(carry_out),
    .Zero(zero), .Overflow(overflow), .DbgState(dbg_state)
  );

  // ALU_1bit: B optionally inverted; full-adder carry; Operation selects the output.
  always_comb begin
    logic b_eff;
    b_eff  = s_b ^ s_binv;
    s_cout = (s_a & b_eff) | (s_a & s_cin) | (b_eff & s_cin);
    case (s_oper)
      2'b00:   s_res = s_a & b_eff;
      2'b01:   s_res = s_a | b_eff;
      2'b10:   s_res = s_a ^ b_eff ^ s_cin;
      default: s_res = s_a ^ b_eff;
    endcase
  end

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic s,
                                 output logic [W-1:0] r, output logic co, output logic ov);
    logic [W-1:0] bx;
    logic [W:0]   sum;
    logic [W-1:0] low;
    bx = s ? ~b : b;
    co = 1'b0;
    ov = 1'b0;
    case (op)
      2'b00: r = a & bx;
      2'b01: r = a | bx;
      2'b11: r = a ^ bx;
      default: begin
        sum = {1'b0, a} + {1'b0, bx} + (W+1)'(s);
        r   = sum[W-1:0];
        co  = sum[W];
        low = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + W'(s);
        ov  = low[W-1] ^ co;
      end
    endcase
  endfunction

  // Starts one op and waits for Done; lat is the cycle index of Done (0 = timeout).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic s, output int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; alu_op = op; sub = s;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = done ? n : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; alu_op = 2'b00; sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, carry_out, overflow, zero} !== 5'b00001 || result !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b co=%b ov=%b zero=%b result=%h st=%0d required 0 0 0 0 1 0000 0",
               busy, done, carry_out, overflow, zero, result, dbg_state);
    end
    checks++;
    if ({s_a, s_b, s_cin, s_binv, s_oper} !== 6'b0) begin
      errors++;
      $display("FAIL reset_slice_idle: slice=%b required 000000", {s_a, s_b, s_cin, s_binv, s_oper});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t v[8];
    int lat;
    v[0] = '{16'h1234, 16'h0FFF, 2'b10, 1'b0, 16'h2233, 1'b0, 1'b0};
    v[1] = '{16'h7FFF, 16'h0001, 2'b10, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[2] = '{16'hFFFF, 16'h0001, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[3] = '{16'h0005, 16'h0005, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b0};
    v[4] = '{16'h0003, 16'h0005, 2'b10, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[5] = '{16'hF0F0, 16'h3C3C, 2'b00, 1'b0, 16'h3030, 1'b0, 1'b0};
    v[6] = '{16'hF0F0, 16'h3C3C, 2'b01, 1'b0, 16'hFCFC, 1'b0, 1'b0};
    v[7] = '{16'hFFFF, 16'hAAAA, 2'b11, 1'b0, 16'h5555, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].a, v[i].b, v[i].op, v[i].s, lat);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, LAT);
      end
      checks++;
      if (result !== v[i].r || carry_out !== v[i].co || overflow !== v[i].ov || zero !== (v[i].r == '0)) begin
        errors++;
        $display("FAIL directed_result[%0d]: r=%h co=%b ov=%b z=%b required r=%h co=%b ov=%b z=%b",
                 i, result, carry_out, overflow, zero, v[i].r, v[i].co, v[i].ov, v[i].r == '0);
      end
    end
    // Outputs hold through IDLE.
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 16'h5555 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_in_idle: r=%h busy=%b done=%b required 5555 0 0", result, busy, done);
    end
  endtask

  task automatic test_start_ignored();
    int n, dones, first;
    @(negedge clk);
    start = 1'b1; op_a = 16'h1234; op_b = 16'h0FFF; alu_op = 2'b10; sub = 1'b0;
    dones = 0; first = 0;
    for (n = 1; n <= 25; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (n == 5) begin
        op_a = 16'hAAAA; op_b = 16'h5555; alu_op = 2'b11; sub = 1'b1;
      end
      if (done) begin
        dones++;
        if (first == 0) begin
          first = n;
          checks++;
          if (result !== 16'h2233 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_result: r=%h co=%b required 2233 0", result, carry_out);
          end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dones !== 1 || first !== LAT) begin
      errors++;
      $display("FAIL start_ignored_done: count=%0d at=%0d required 1 at %0d", dones, first, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    logic [W-1:0] er;
    logic eco, eov;
    do_op(16'h00FF, 16'h0F0F, 2'b00, 1'b0, lat);
    checks++;
    if (lat !== LAT || result !== 16'h000F) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d r=%h required %0d 000f", lat, result, LAT);
    end
    start = 1'b1; op_a = 16'h8000; op_b = 16'h8000; alu_op = 2'b10; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_next: busy=%b done=%b required 1 0", busy, done);
    end
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    ref_op(16'h8000, 16'h8000, 2'b10, 1'b0, er, eco, eov);
    checks++;
    if (!done || n !== LAT || result !== er || carry_out !== eco || overflow !== eov || zero !== (er == '0)) begin
      errors++;
      $display("FAIL b2b_second: done=%b at=%0d r=%h co=%b ov=%b z=%b required at %0d r=%h co=%b ov=%b",
               done, n, result, carry_out, overflow, zero, LAT, er, eco, eov);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones, lat;
    @(negedge clk);
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; alu_op = 2'b10; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== '0 || zero !== 1'b1 || done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b r=%h zero=%b done=%b st=%0d required 0 0000 1 0 0",
               busy, result, zero, done, dbg_state);
    end
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d Done pulses required 0", dones);
    end
    do_op(16'h1111, 16'h2222, 2'b10, 1'b0, lat);
    checks++;
    if (lat !== LAT || result !== 16'h3333 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d r=%h z=%b required %0d 3333 0", lat, result, zero, LAT);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, er;
    logic [1:0] op;
    logic s, eco, eov;
    for (int i = 0; i < 1000; i++) begin
      a  = W'($urandom_range(0, 65535));
      b  = W'($urandom_range(0, 65535));
      op = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      if (i < 4) a = (i < 2) ? 16'hFFFF : 16'h0000;
      ref_op(a, b, op, s, er, eco, eov);
      do_op(a, b, op, s, lat);
      checks++;
      if (lat !== LAT || result !== er || carry_out !== eco || overflow !== eov || zero !== (er == '0)) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h op=%b sub=%b: lat=%0d r=%h co=%b ov=%b z=%b required %0d r=%h co=%b ov=%b z=%b",
                 i, a, b, op, s, lat, result, carry_out, overflow, zero, LAT, er, eco, eov, er == '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_bit_serial_sequencer.md
Name: alu_bit_serial_sequencer

Overview:
Bit-serial controller that drives the single-bit ALU slice (ALU_1bit) once per clock, from LSB to MSB, to perform a full WIDTH-bit operation. It sits between the decode/register stage and the slice. It accepts a full-width operand pair and opcode, sequences A, B, CIN, BInvert and Operation into the slice, and collects Result and COUT. It returns the assembled WIDTH-bit result with carry, zero and overflow flags under a start/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; equals the number of serial cycles per operation.

Ports:
Clock  input  1  system clock; all state changes on rising edge.
Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
Start  input  1  request pulse; accepted only in IDLE or DONE.
OpA  input  WIDTH  operand A; latched on accepted Start.
OpB  input  WIDTH  operand B; latched on accepted Start.
ALUOp  input  2  00 AND, 01 OR, 10 ADD, 11 XOR; latched on accepted Start.
Sub  input  1  1 = invert B and force carry-in of bit 0 to 1 (subtract with ADD); latched on accepted Start.
SliceA  output  1  A bit to slice.
SliceB  output  1  B bit to slice.
SliceCIN  output  1  carry-in to slice.
SliceBInvert  output  1  BInvert to slice.
SliceOperation  output  2  Operation to slice.
SliceResult  input  1  Result from slice, combinational in the same cycle.
SliceCOUT  input  1  COUT from slice, combinational in the same cycle.
Busy  output  1  high in RUN.
Done  output  1  one-cycle pulse in DONE.
Result  output  WIDTH  assembled result; held until the next accepted Start.
CarryOut  output  1  final COUT for ADD; 0 for other ops.
Zero  output  1  Result == 0.
Overflow  output  1  signed overflow for ADD (carry into MSB XOR carry out of MSB); 0 for other ops.

Behaviour:
- States: IDLE, RUN, DONE. Reset (Reset=0 at edge) forces IDLE. Reset clears Result, CarryOut, Overflow, Busy, Done and the bit index; Zero reads 1. Reset mid-RUN abandons the operation; no Done is produced.
- IDLE/DONE + Start=1: latch OpA, OpB, ALUOp and Sub. Set bit index to 0 and carry register to Sub. Clear the result shift register. Go to RUN.
- IDLE + Start=0: stay. DONE + Start=0: go to IDLE.
- RUN, each cycle:
  - Slice driven combinationally: SliceA = OpA_latched[idx], SliceB = OpB_latched[idx], SliceCIN = carry register, SliceBInvert = Sub_latched, SliceOperation = ALUOp_latched.
  - At the edge: result bit idx <= SliceResult; carry register <= SliceCOUT; idx++.
  - When idx = WIDTH-1, also record the MSB carry-in (current carry register) and go to DONE.
- DONE: Done=1 for exactly this cycle. Result, CarryOut and Overflow are registered and valid in this cycle. They remain stable through IDLE until the next accepted Start.
- Outside RUN, all Slice* outputs are driven to 0.
- Start while in RUN is ignored; latched operands must not change.
- Latency: Start accepted at edge t puts Busy high for cycles t+1..t+WIDTH. Done is high in cycle t+WIDTH+1.
- Back-to-back: Start in the DONE cycle is accepted, so the next RUN begins immediately. Throughput is one operation per WIDTH+1 cycles.
- The carry chain is internal to the sequencer; the slice's COUT is never used as a combinational feed back into SliceCIN in the same cycle.
- Zero is computed from the registered Result.

Test Plan:
- ALUOp=10, Sub=0, OpA=0x1234, OpB=0x0FFF -> Done at t+17, Result=0x2233, CarryOut=0, Overflow=0, Zero=0.
- ALUOp=10, Sub=0, OpA=0x7FFF, OpB=0x0001 -> Result=0x8000, Overflow=1, CarryOut=0. Then OpA=0xFFFF, OpB=0x0001 -> Result=0x0000, CarryOut=1, Zero=1, Overflow=0.
- ALUOp=10, Sub=1, OpA=0x0005, OpB=0x0005 -> Result=0x0000, Zero=1, CarryOut=1. OpA=0x0003, OpB=0x0005 -> Result=0xFFFE, CarryOut=0.
- ALUOp=00, OpA=0xF0F0, OpB=0x3C3C -> Result=0x3030. ALUOp=01 -> 0xFCFC. ALUOp=11, OpA=0xFFFF, OpB=0xAAAA -> 0x5555. In all three, CarryOut=0 and Overflow=0.
- Start pulsed again at cycle t+5 with different operands -> ignored; the first result is unchanged and Done fires once at t+17. Start asserted during the DONE cycle -> second op accepted and Busy is high the next cycle.
- Reset=0 at cycle t+8 of an ADD -> IDLE next cycle; Busy=0, Result=0, Zero=1, no Done pulse. A subsequent op completes correctly.
- The bench connects the Slice* ports to an ALU_1bit instance and checks every Result against a reference model over 1000 random operand/op/Sub combinations.
